ro_counter_array: RTL and testbench



---
 rtl/ro_counter_array.sv | 232 +++++++++++++++++++++++
 tb/tb_ro_counter_array.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_counter_array.sv
// N-channel ring-oscillator frequency counter with an Avalon-MM register file
// and a conduit export of the selected channel's latched count.
module ro_counter_array #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int GATE_RST = 50000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [4:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [NUM_CH-1:0] ro_in,
    output logic [NUM_CH-1:0] ro_enable,
    output logic [31:0]       export_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_r;
    logic [1:0]         arm_cnt_r;
    logic [31:0]        gate_cnt_r;
    logic [31:0]        act_gate_r;
    logic [NUM_CH-1:0]  act_mask_r;
    logic               act_cont_r;
    logic [CNT_W-1:0]   cnt_r    [NUM_CH];
    logic [CNT_W-1:0]   result_r [NUM_CH];
    logic [NUM_CH-1:0]  ovf_r;
    logic               done_r;
    logic               cont_r;
    logic [3:0]         sel_r;
    logic [NUM_CH-1:0]  mask_r;
    logic [31:0]        gate_r;
    logic [31:0]        readdata_r;
    logic [31:0]        export_r;
    logic [NUM_CH-1:0]  ro_enable_r;
    logic [NUM_CH-1:0]  sync1_r, sync2_r, sync3_r;

    logic               ctrl_wr_s, gate_wr_s, start_s, stop_s, done_clr_s, latch_fire_s, busy_s;
    logic [NUM_CH-1:0]  mask_nxt_s, edge_s;
    logic               cont_nxt_s;
    logic [3:0]         sel_nxt_s;
    logic [31:0]        cnt_ext_s [NUM_CH];
    logic [31:0]        res_ext_s [NUM_CH];
    logic [31:0]        cnt_mux_s, res_mux_s, rd_result_s, rd_data_s;

    // Bus decode, next-value views of CTRL fields and result selection.
    always_comb begin
        ctrl_wr_s    = write && (address == 5'd0);
        gate_wr_s    = write && (address == 5'd2);
        start_s      = ctrl_wr_s && writedata[0];
        stop_s       = ctrl_wr_s && writedata[2];
        done_clr_s   = write && (address == 5'd1) && writedata[1];
        busy_s       = (state_r != ST_IDLE);
        latch_fire_s = (state_r == ST_LATCH) && !stop_s;
        mask_nxt_s   = ctrl_wr_s ? writedata[8 +: NUM_CH] : mask_r;
        cont_nxt_s   = ctrl_wr_s ? writedata[1] : cont_r;
        sel_nxt_s    = ctrl_wr_s ? writedata[7:4] : sel_r;
        edge_s       = sync2_r & ~sync3_r;
        cnt_mux_s    = 32'd0;
        res_mux_s    = 32'd0;
        rd_result_s  = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_ext_s[i] = 32'd0;
            cnt_ext_s[i][CNT_W-1:0] = cnt_r[i];
            res_ext_s[i] = 32'd0;
            res_ext_s[i][CNT_W-1:0] = result_r[i];
            cnt_mux_s   = cnt_mux_s   | ((sel_nxt_s == 4'(i)) ? cnt_ext_s[i] : 32'd0);
            res_mux_s   = res_mux_s   | ((sel_nxt_s == 4'(i)) ? res_ext_s[i] : 32'd0);
            rd_result_s = rd_result_s | ((address == 5'(4 + i)) ? res_ext_s[i] : 32'd0);
        end
    end

    // Register read multiplexer; unmapped words read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (address)
            5'd0: begin
                rd_data_s[1]            = cont_r;
                rd_data_s[7:4]          = sel_r;
                rd_data_s[8 +: NUM_CH]  = mask_r;
            end
            5'd1: begin
                rd_data_s[0]            = busy_s;
                rd_data_s[1]            = done_r;
                rd_data_s[16 +: NUM_CH] = ovf_r;
            end
            5'd2:    rd_data_s = gate_r;
            default: rd_data_s = rd_result_s;
        endcase
    end

    // Two-flop synchroniser plus previous-value flop for rising-edge detection.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            sync3_r <= '0;
        end else begin
            sync1_r <= ro_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cont_r <= 1'b0;
            sel_r  <= 4'd0;
            mask_r <= '1;
            gate_r <= 32'(GATE_RST);
        end else begin
            if (ctrl_wr_s) begin
                cont_r <= writedata[1];
                sel_r  <= writedata[7:4];
                mask_r <= writedata[8 +: NUM_CH];
            end
            if (gate_wr_s) begin
                gate_r <= writedata;
            end
        end
    end

    // Measurement FSM with the edge counters; STOP overrides every state.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r     <= ST_IDLE;
            arm_cnt_r   <= 2'd0;
            gate_cnt_r  <= 32'd0;
            act_gate_r  <= 32'd0;
            act_mask_r  <= '0;
            act_cont_r  <= 1'b0;
            ovf_r       <= '0;
            ro_enable_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]    <= '0;
                result_r[i] <= '0;
            end
        end else if (stop_s) begin
            state_r     <= ST_IDLE;
            ro_enable_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_ARM;
                        arm_cnt_r   <= 2'd2;
                        act_mask_r  <= mask_nxt_s;
                        act_cont_r  <= cont_nxt_s;
                        act_gate_r  <= gate_r;
                        ro_enable_r <= mask_nxt_s;
                        ovf_r       <= '0;
                    end
                end
                ST_ARM: begin
                    for (int i = 0; i < NUM_CH; i++) cnt_r[i] <= '0;
                    if (arm_cnt_r == 2'd0) begin
                        state_r    <= ST_GATE;
                        gate_cnt_r <= (act_gate_r == 32'd0) ? 32'd1 : act_gate_r;
                    end else begin
                        arm_cnt_r <= arm_cnt_r - 2'd1;
                    end
                end
                ST_GATE: begin
                    // A saturated counter holds; an edge it cannot absorb flags overflow.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (act_mask_r[i] && edge_s[i]) begin
                            if (cnt_r[i] == CNT_MAX) ovf_r[i] <= 1'b1;
                            else                     cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    if (gate_cnt_r <= 32'd1) state_r    <= ST_LATCH;
                    else                     gate_cnt_r <= gate_cnt_r - 32'd1;
                end
                ST_LATCH: begin
                    for (int i = 0; i < NUM_CH; i++) result_r[i] <= cnt_r[i];
                    if (act_cont_r) begin
                        state_r     <= ST_ARM;
                        arm_cnt_r   <= 2'd2;
                        act_mask_r  <= mask_nxt_s;
                        act_cont_r  <= cont_nxt_s;
                        act_gate_r  <= gate_r;
                        ro_enable_r <= mask_nxt_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        ro_enable_r <= '0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ro_enable_r <= '0;
                end
            endcase
        end
    end

    // Sticky DONE; a set from LATCH beats a simultaneous clear.
    always_ff @(posedge clk_clk) begin
        if (reset_reset)       done_r <= 1'b0;
        else if (latch_fire_s) done_r <= 1'b1;
        else if (done_clr_s)   done_r <= 1'b0;
    end

    // Export follows LATCH, or a SEL change re-selects from RESULT at once.
    always_ff @(posedge clk_clk) begin
        if (reset_reset)       export_r <= 32'd0;
        else if (latch_fire_s) export_r <= cnt_mux_s;
        else if (ctrl_wr_s)    export_r <= res_mux_s;
    end

    // Read data with one cycle of latency, captured before any same-cycle write.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) readdata_r <= 32'd0;
        else if (read)   readdata_r <= rd_data_s;
        else             readdata_r <= 32'd0;
    end

    assign readdata    = readdata_r;
    assign export_data = export_r;
    assign ro_enable   = ro_enable_r;

endmodule

// File: tb/tb_ro_counter_array.sv
// Directed, self-checking bench for ro_counter_array: a register-access vector
// table followed by hand-timed measurement sequences.
module tb_ro_counter_array;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [4:0]  address;
    logic        read, write;
    logic [31:0] writedata, readdata, export_data;
    logic [3:0]  ro_in, ro_enable;

    int n_tests = 0;
    int n_fail  = 0;
    int ro_mode [4];
    int ph = 0;
    logic [31:0] q;

    ro_counter_array #(.NUM_CH(4), .CNT_W(8), .GATE_RST(50000)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .address(address),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .ro_in(ro_in), .ro_enable(ro_enable), .export_data(export_data)
    );

    always #5 clk_clk = ~clk_clk;

    // Oscillator models: 0 = static low, 1 = clk/2, 2 = clk/4.
    initial begin
        ro_in = 4'd0;
        forever begin
            @(negedge clk_clk);
            ph = ph + 1;
            for (int c = 0; c < 4; c++) begin
                if (ro_mode[c] == 1)      ro_in[c] = ~ro_in[c];
                else if (ro_mode[c] == 2) ro_in[c] = ph[1];
                else                      ro_in[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input logic [31:0] act, input int lo, input int hi);
        n_tests++;
        if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Bus tasks start and end at a falling edge; one rising edge in between.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk_clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk_clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic bus_rw(input logic [4:0] a, input logic [31:0] wd, output logic [31:0] d);
        address = a; writedata = wd; read = 1'b1; write = 1'b1;
        @(negedge clk_clk);
        read = 1'b0; write = 1'b0;
        d = readdata;
    endtask

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1'b0, 5'd2,  32'd0,         32'd50000};
        vecs[1]  = '{1'b0, 5'd1,  32'd0,         32'h0000_0000};
        vecs[2]  = '{1'b0, 5'd0,  32'd0,         32'h0000_0F00};
        vecs[3]  = '{1'b0, 5'd4,  32'd0,         32'h0000_0000};
        vecs[4]  = '{1'b0, 5'd3,  32'd0,         32'h0000_0000};
        vecs[5]  = '{1'b0, 5'd31, 32'd0,         32'h0000_0000};
        vecs[6]  = '{1'b1, 5'd2,  32'd100,       32'd0};
        vecs[7]  = '{1'b0, 5'd2,  32'd0,         32'd100};
        vecs[8]  = '{1'b1, 5'd4,  32'h0000_00FF, 32'd0};
        vecs[9]  = '{1'b0, 5'd4,  32'd0,         32'h0000_0000};
        vecs[10] = '{1'b1, 5'd0,  32'h0000_0522, 32'd0};
        vecs[11] = '{1'b0, 5'd0,  32'd0,         32'h0000_0522};
        vecs[12] = '{1'b1, 5'd0,  32'h0000_0F00, 32'd0};
        vecs[13] = '{1'b1, 5'd1,  32'hFFFF_FFFF, 32'd0};
        vecs[14] = '{1'b0, 5'd1,  32'd0,         32'h0000_0000};

        for (int c = 0; c < 4; c++) ro_mode[c] = 0;
        reset_reset = 1'b1; address = 5'd0; read = 1'b0; write = 1'b0; writedata = 32'd0;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        chk("rst_ro_enable", {28'd0, ro_enable}, 32'd0);
        chk("rst_export", export_data, 32'd0);
        chk("rst_readdata", readdata, 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, q);
                chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), q, vecs[i].exp);
            end
        end

        // GATE=100, ch0 at clk/4: LATCH at T+104, results visible at T+105.
        ro_mode[0] = 2;
        bus_write(5'd0, 32'h0000_0F01);
        chk("m1_ro_enable", {28'd0, ro_enable}, 32'h0000_000F);
        repeat (103) @(negedge clk_clk);
        chk("m1_export_pre", export_data, 32'd0);
        bus_read(5'd1, q);
        chk("m1_status_latch", q, 32'h0000_0001);
        chk_rng("m1_export", export_data, 24, 26);
        bus_read(5'd1, q);
        chk("m1_status_done", q, 32'h0000_0002);
        bus_read(5'd4, q);
        chk_rng("m1_result0", q, 24, 26);
        bus_read(5'd5, q);
        chk("m1_result1", q, 32'd0);

        // Overflow: 8-bit counter, ch1 at clk/2 for 1000 cycles.
        ro_mode[0] = 0; ro_mode[1] = 1;
        bus_write(5'd2, 32'd1000);
        bus_write(5'd1, 32'h0000_0002);
        bus_write(5'd0, 32'h0000_0F01);
        repeat (1004) @(negedge clk_clk);
        bus_read(5'd1, q);
        chk("ovf_status", q, 32'h0002_0002);
        bus_read(5'd5, q);
        chk("ovf_result1", q, 32'd255);
        bus_read(5'd4, q);
        chk("ovf_result0", q, 32'd0);
        ro_mode[1] = 0;
        bus_write(5'd0, 32'h0000_0F01);
        bus_read(5'd1, q);
        chk("ovf_cleared_on_start", q, 32'h0000_0003);
        bus_write(5'd0, 32'h0000_0F04);
        bus_read(5'd1, q);
        chk("stop_status", q, 32'h0000_0002);
        bus_read(5'd5, q);
        chk("stop_result_kept", q, 32'd255);

        // Channel mask 0101 with every input toggling.
        for (int c = 0; c < 4; c++) ro_mode[c] = 2;
        bus_write(5'd2, 32'd100);
        bus_write(5'd1, 32'h0000_0002);
        bus_write(5'd0, 32'h0000_0501);
        chk("mask_ro_enable_arm", {28'd0, ro_enable}, 32'h0000_0005);
        repeat (50) @(negedge clk_clk);
        chk("mask_ro_enable_gate", {28'd0, ro_enable}, 32'h0000_0005);
        repeat (54) @(negedge clk_clk);
        bus_read(5'd4, q);
        chk_rng("mask_result0", q, 24, 26);
        bus_read(5'd5, q);
        chk("mask_result1", q, 32'd0);
        bus_read(5'd6, q);
        chk_rng("mask_result2", q, 24, 26);
        bus_read(5'd7, q);
        chk("mask_result3", q, 32'd0);
        chk("mask_ro_enable_idle", {28'd0, ro_enable}, 32'd0);

        // Continuous, GATE=10: LATCHes at T+14 and T+28, STOP during third gate.
        for (int c = 0; c < 4; c++) ro_mode[c] = 0;
        bus_write(5'd2, 32'd10);
        bus_write(5'd1, 32'h0000_0002);
        repeat (4) @(negedge clk_clk);
        bus_write(5'd0, 32'h0000_0F03);
        repeat (14) @(negedge clk_clk);
        chk("cont_export_first", export_data, 32'd0);
        ro_mode[0] = 2;
        bus_read(5'd1, q);
        chk("cont_done1", q, 32'h0000_0003);
        bus_write(5'd1, 32'h0000_0002);
        bus_read(5'd1, q);
        chk("cont_done1_cleared", q, 32'h0000_0001);
        repeat (11) @(negedge clk_clk);
        ro_mode[0] = 1;
        bus_read(5'd1, q);
        chk("cont_done2", q, 32'h0000_0003);
        chk_rng("cont_export_second", export_data, 1, 4);
        bus_write(5'd1, 32'h0000_0002);
        repeat (3) @(negedge clk_clk);
        bus_write(5'd0, 32'h0000_0F04);
        chk("cont_stop_ro_enable", {28'd0, ro_enable}, 32'd0);
        bus_read(5'd1, q);
        chk("cont_stop_busy", q, 32'h0000_0000);
        repeat (30) @(negedge clk_clk);
        bus_read(5'd1, q);
        chk("cont_no_third_done", q, 32'h0000_0000);
        bus_read(5'd4, q);
        chk_rng("cont_result_second", q, 1, 4);

        // GATE=0 behaves as a 1-cycle window; DONE-clear collides with LATCH.
        bus_write(5'd2, 32'd0);
        bus_write(5'd0, 32'h0000_0F01);
        repeat (4) @(negedge clk_clk);
        bus_rw(5'd1, 32'h0000_0002, q);
        chk("g0_status_latch", q, 32'h0000_0001);
        bus_read(5'd1, q);
        chk("g0_done_set_wins", q, 32'h0000_0002);

        // Same-cycle read and write returns the old value.
        bus_rw(5'd2, 32'd20, q);
        chk("rw_pre_write", q, 32'd0);
        bus_read(5'd2, q);
        chk("rw_post_write", q, 32'd20);

        // Reset in the middle of a gate window.
        ro_mode[0] = 2;
        bus_write(5'd0, 32'h0000_0F01);
        repeat (30) @(negedge clk_clk);
        chk_rng("pre_rst_export", export_data, 4, 6);
        bus_write(5'd0, 32'h0000_0F01);
        repeat (8) @(negedge clk_clk);
        chk("pre_rst_ro_enable", {28'd0, ro_enable}, 32'h0000_000F);
        reset_reset = 1'b1; read = 1'b1; address = 5'd2;
        @(negedge clk_clk);
        reset_reset = 1'b0; read = 1'b0;
        chk("midrst_export", export_data, 32'd0);
        chk("midrst_ro_enable", {28'd0, ro_enable}, 32'd0);
        chk("midrst_readdata", readdata, 32'd0);
        bus_read(5'd2, q);
        chk("midrst_gate", q, 32'd50000);
        bus_read(5'd1, q);
        chk("midrst_status", q, 32'd0);
        bus_read(5'd0, q);
        chk("midrst_ctrl", q, 32'h0000_0F00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
